// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_pkg                                               |
// | Purpose  : Shared types and helpers for the multi-port register file |
// |            (sweep FSM states, address-width derivation, zero word).  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package regfile_pkg;

  // Clear-sweep controller states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // Widest data word the zero constant covers; slices are taken from it
  localparam int MAX_WORD_LEN = 128;
  localparam logic [MAX_WORD_LEN-1:0] ZERO_WORD = '0;

  // Address width: at least one bit even for tiny register files
  function automatic int calc_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_mp_if                                             |
// | Purpose  : Bus bundle between decode/writeback (master) and the      |
// |            register file (slave): reads, writes, issue, clear.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WORD_LEN   = 32,
  parameter int WORD_COUNT = 32,
  parameter int READ_PORTS = 2
);
  localparam int AW = calc_aw(WORD_COUNT);

  logic [READ_PORTS*AW-1:0]       rd_addr;
  logic [READ_PORTS*WORD_LEN-1:0] rd_data;
  logic [READ_PORTS-1:0]          rd_pend;
  logic                           wr0_en;
  logic [AW-1:0]                  wr0_addr;
  logic [WORD_LEN-1:0]            wr0_data;
  logic                           wr1_en;
  logic [AW-1:0]                  wr1_addr;
  logic [WORD_LEN-1:0]            wr1_data;
  logic                           issue_en;
  logic [AW-1:0]                  issue_addr;
  logic                           clr_req;
  logic                           clr_busy;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr, clr_req,
    input  rd_data, rd_pend, clr_busy
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr, clr_req,
    output rd_data, rd_pend, clr_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_scoreboard                                        |
// | Purpose  : Pending-write bit per register. Set on issue, cleared by  |
// |            a write or by the clear sweep; looked up per read port.   |
// |            Callers pass already-qualified enables.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module regfile_scoreboard #(
  parameter int WORD_COUNT = 32,
  parameter int READ_PORTS = 2,
  parameter int AW         = 5
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_set_en,
  input  wire logic [AW-1:0]          i_set_addr,
  input  wire logic                   i_clr0_en,
  input  wire logic [AW-1:0]          i_clr0_addr,
  input  wire logic                   i_clr1_en,
  input  wire logic [AW-1:0]          i_clr1_addr,
  input  wire logic                   i_sweep_en,
  input  wire logic [AW-1:0]          i_sweep_idx,
  input  wire logic [READ_PORTS*AW-1:0] i_rd_addr,
  input  wire logic [READ_PORTS-1:0]  i_rd_ok,
  output logic      [READ_PORTS-1:0]  o_pend
);

  logic [WORD_COUNT-1:0] r_busy;

  // Busy bits: sweep clear first, then issue (newest producer) over write release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        if (i_sweep_en && (i_sweep_idx == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end else if (i_set_en && (i_set_addr == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((i_clr0_en && (i_clr0_addr == AW'(i))) ||
                     (i_clr1_en && (i_clr1_addr == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_pend
    logic [AW-1:0] w_addr;
    assign w_addr    = i_rd_addr[k*AW +: AW];
    assign o_pend[k] = i_rd_ok[k] & r_busy[w_addr];
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_mp                                                |
// | Purpose  : Multi-port register file: N combinational reads, two      |
// |            prioritised writes (wr1 wins), pending-write scoreboard   |
// |            and a one-register-per-cycle clear sweep.                 |
// |            Option macro REGFILE_BYPASS_EN: same-cycle write-through  |
// |            forwarding to the read ports.                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WORD_LEN   = 32,
  parameter int WORD_COUNT = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input wire logic   clk,
  input wire logic   rst,
  regfile_mp_if.slave bus
);

  localparam int AW = calc_aw(WORD_COUNT);

  logic [WORD_LEN-1:0] r_mem [WORD_COUNT];
  state_e              r_state;
  state_e              w_state_nxt;
  logic [AW-1:0]       r_idx;
  logic                w_sweep;
  logic                w_last;
  logic                w_wr0_ok;
  logic                w_wr1_ok;
  logic                w_issue_ok;
  logic [READ_PORTS-1:0] w_rd_ok;
  logic [READ_PORTS-1:0] w_sb_pend;
  logic [READ_PORTS-1:0] w_hit;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(WORD_COUNT));
  endfunction

  // Writable target: in range and not the hard-wired zero register
  function automatic logic writable(input logic [AW-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_sweep    = (r_state == SWEEP);
  assign w_last     = (r_idx == AW'(WORD_COUNT - 1));
  assign w_wr0_ok   = bus.wr0_en   && !w_sweep && writable(bus.wr0_addr);
  assign w_wr1_ok   = bus.wr1_en   && !w_sweep && writable(bus.wr1_addr);
  assign w_issue_ok = bus.issue_en && !w_sweep && writable(bus.issue_addr);
  assign bus.clr_busy = w_sweep;

  // Storage: sweep zeroes one entry per cycle, otherwise wr1 lands after wr0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        r_mem[i] <= ZERO_WORD[WORD_LEN-1:0];
      end
    end else if (w_sweep) begin
      r_mem[r_idx] <= ZERO_WORD[WORD_LEN-1:0];
    end else begin
      if (w_wr0_ok) r_mem[bus.wr0_addr] <= bus.wr0_data;
      if (w_wr1_ok) r_mem[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  // Sweep controller state and index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sweep) r_idx <= w_last ? '0 : r_idx + AW'(1);
    end
  end

  // Next state: clr_req only matters while idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.clr_req) w_state_nxt = SWEEP;
      SWEEP:   if (w_last)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [AW-1:0]       w_a;
    logic [WORD_LEN-1:0] w_stored;
    assign w_a        = bus.rd_addr[k*AW +: AW];
    assign w_rd_ok[k] = in_range(w_a);
    assign w_stored   = w_rd_ok[k] ? r_mem[w_a] : ZERO_WORD[WORD_LEN-1:0];
`ifdef REGFILE_BYPASS_EN
    logic w_hit0;
    logic w_hit1;
    assign w_hit0   = w_wr0_ok && (bus.wr0_addr == w_a);
    assign w_hit1   = w_wr1_ok && (bus.wr1_addr == w_a);
    assign w_hit[k] = w_hit0 | w_hit1;
    assign bus.rd_data[k*WORD_LEN +: WORD_LEN] =
      w_hit1 ? bus.wr1_data : (w_hit0 ? bus.wr0_data : w_stored);
`else
    assign w_hit[k] = 1'b0;
    assign bus.rd_data[k*WORD_LEN +: WORD_LEN] = w_stored;
`endif
  end

  // A forwarded write resolves the hazard in the same cycle
  assign bus.rd_pend = w_sb_pend & ~w_hit;

  regfile_scoreboard #(
    .WORD_COUNT(WORD_COUNT),
    .READ_PORTS(READ_PORTS),
    .AW        (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_issue_ok),
    .i_set_addr (bus.issue_addr),
    .i_clr0_en  (w_wr0_ok),
    .i_clr0_addr(bus.wr0_addr),
    .i_clr1_en  (w_wr1_ok),
    .i_clr1_addr(bus.wr1_addr),
    .i_sweep_en (w_sweep),
    .i_sweep_idx(r_idx),
    .i_rd_addr  (bus.rd_addr),
    .i_rd_ok    (w_rd_ok),
    .o_pend     (w_sb_pend)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_regfile_mp                                             |
// | Purpose  : Directed scoreboard bench for regfile_mp (2 read ports,   |
// |            32 x 32-bit, R0 hard-wired); expectations follow the      |
// |            REGFILE_BYPASS_EN build option.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int WL = 32;
  localparam int WC = 32;
  localparam int RP = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.WORD_LEN(WL), .WORD_COUNT(WC), .READ_PORTS(RP)) bus ();

  regfile_mp #(.WORD_LEN(WL), .WORD_COUNT(WC), .READ_PORTS(RP), .ZERO_REG(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  pend;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic chk_valid = 1'b0;

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (chk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL no_expectation: got data=%h pend=%b busy=%b, required a queued entry",
                 bus.rd_data, bus.rd_pend, bus.clr_busy);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_data !== {e.d1, e.d0} || bus.rd_pend !== e.pend || bus.clr_busy !== e.busy) begin
          failures++;
          $display("FAIL %s: got data=%h pend=%b busy=%b, required data=%h pend=%b busy=%b",
                   e.name, bus.rd_data, bus.rd_pend, bus.clr_busy, {e.d1, e.d0}, e.pend, e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr0_en = 1'b0; bus.wr1_en = 1'b0; bus.issue_en = 1'b0; bus.clr_req = 1'b0;
  endtask

  task automatic set_wr0(input logic [4:0] a, input logic [31:0] d);
    bus.wr0_en = 1'b1; bus.wr0_addr = a; bus.wr0_data = d;
  endtask

  task automatic set_wr1(input logic [4:0] a, input logic [31:0] d);
    bus.wr1_en = 1'b1; bus.wr1_addr = a; bus.wr1_data = d;
  endtask

  task automatic set_issue(input logic [4:0] a);
    bus.issue_en = 1'b1; bus.issue_addr = a;
  endtask

  // Present read addresses, queue the expected response, spend one cycle
  task automatic check(input string nm, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] p, input logic b);
    exp_t e;
    bus.rd_addr = {a1, a0};
    e.name = nm; e.d0 = d0; e.d1 = d1; e.pend = p; e.busy = b;
    exp_q.push_back(e);
    chk_valid = 1'b1;
    tick();
    chk_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout: got no completion, required finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit done;
    bus.rd_addr = '0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_addr = '0; bus.wr1_data = '0; bus.issue_addr = '0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_a", 5'd0, 5'd1, 32'h0, 32'h0, 2'b00, 1'b0);
    check("reset_b", 5'd2, 5'd3, 32'h0, 32'h0, 2'b00, 1'b0);

    // Write-port priority, R0 protection, independent dual write
    set_wr0(5'd5, 32'hAAAA_0000); set_wr1(5'd5, 32'h5555_FFFF); tick();
    set_wr0(5'd0, 32'h0000_0001); set_wr1(5'd6, 32'h0000_0066); tick();
    set_wr0(5'd8, 32'h0000_0088); set_wr1(5'd10, 32'h0000_1010); tick();
    clear_inputs();
    check("wr1_priority", 5'd5, 5'd0, 32'h5555_FFFF, 32'h0, 2'b00, 1'b0);
    check("r0_dropped",   5'd0, 5'd6, 32'h0, 32'h0000_0066, 2'b00, 1'b0);
    check("dual_write",   5'd8, 5'd10, 32'h0000_0088, 32'h0000_1010, 2'b00, 1'b0);

    // Scoreboard
    set_issue(5'd7); tick(); clear_inputs();
    check("issue_pend", 5'd7, 5'd5, 32'h0, 32'h5555_FFFF, 2'b01, 1'b0);
    set_issue(5'd7); set_wr0(5'd7, 32'h0000_0077); tick(); clear_inputs();
    check("issue_and_write", 5'd7, 5'd7, 32'h77, 32'h77, 2'b11, 1'b0);
    set_wr1(5'd7, 32'h0000_0700);
    check("release_cycle", 5'd7, 5'd6, BYP ? 32'h700 : 32'h77, 32'h66, BYP ? 2'b00 : 2'b01, 1'b0);
    clear_inputs();
    check("release_done", 5'd7, 5'd6, 32'h700, 32'h66, 2'b00, 1'b0);

    // Same-cycle read of a register being written
    set_wr0(5'd3, 32'h0000_1234);
    check("bypass_r3", 5'd3, 5'd3, BYP ? 32'h1234 : 32'h0, BYP ? 32'h1234 : 32'h0, 2'b00, 1'b0);
    clear_inputs();
    check("r3_stored", 5'd3, 5'd0, 32'h1234, 32'h0, 2'b00, 1'b0);
    set_wr0(5'd0, 32'h0000_FFFF);
    check("r0_no_bypass", 5'd0, 5'd3, 32'h0, 32'h1234, 2'b00, 1'b0);
    clear_inputs();

    // Preload, then sweep with writes/issues/clr_req held during it
    for (int i = 1; i < 32; i++) begin
      set_wr0(5'(i), 32'h1000_0000 + 32'(i)); tick();
    end
    clear_inputs();
    set_issue(5'd9); tick(); clear_inputs();
    check("preload", 5'd9, 5'd31, 32'h1000_0009, 32'h1000_001F, 2'b01, 1'b0);
    bus.clr_req = 1'b1; tick();
    set_wr0(5'd2, 32'h0000_DEAD); set_wr1(5'd3, 32'h0000_BEEF); set_issue(5'd4);
    for (int j = 0; j < 32; j++) begin
      check($sformatf("sweep_%0d", j), 5'(j), (j == 0) ? 5'd0 : 5'(j - 1),
            (j == 0) ? 32'h0 : 32'h1000_0000 + 32'(j), 32'h0,
            {1'b0, (j == 9)}, 1'b1);
    end
    bus.wr1_en = 1'b0; bus.issue_en = 1'b0; bus.clr_req = 1'b0;
    check("post_sweep_first", 5'd2, 5'd4, BYP ? 32'hDEAD : 32'h0, 32'h0, 2'b00, 1'b0);
    clear_inputs();
    check("post_sweep_write", 5'd2, 5'd0, 32'hDEAD, 32'h0, 2'b00, 1'b0);
    for (int i = 2; i < 16; i++) begin
      check($sformatf("cleared_%0d", i), 5'(2 * i), 5'(2 * i + 1), 32'h0, 32'h0, 2'b00, 1'b0);
    end
    check("cleared_r1", 5'd1, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Reset in the middle of a sweep
    set_wr0(5'd12, 32'h0000_000C); set_wr1(5'd20, 32'h0000_0020); tick(); clear_inputs();
    set_issue(5'd13); tick(); clear_inputs();
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_sweep", 5'd12, 5'd13, 32'h0, 32'h0, 2'b00, 1'b0);
    check("rst_all_zero", 5'd20, 5'd2, 32'h0, 32'h0, 2'b00, 1'b0);
    rst = 1'b0;
    set_wr0(5'd1, 32'h0000_0005); tick(); clear_inputs();
    bus.clr_req = 1'b1; tick(); bus.clr_req = 1'b0;
    check("resweep_c0", 5'd1, 5'd0, 32'h5, 32'h0, 2'b00, 1'b1);
    check("resweep_c1", 5'd1, 5'd0, 32'h5, 32'h0, 2'b00, 1'b1);
    check("resweep_c2", 5'd1, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1);

    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.clr_busy === 1'b0) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL resweep_end: got clr_busy=%b after 40 cycles, required 0", bus.clr_busy);
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
